// File: rtl/ts_os_detector.sv
// TS1/TS2 ordered-set detector: 4 symbols/clk, 8b/10b (COM based) or 128b/130b (sync-header based).
// Optional macro TS_OS_ERR_CNT_EN enables the saturating malformed-OS counter on errCount.
module ts_os_detector (
    input  logic        clk,
    input  logic        reset,
    input  logic        gen3Mode,
    input  logic        descramblerDataValid,
    input  logic [1:0]  descramblerSyncHeader,
    input  logic [31:0] descramblerData,
    input  logic [3:0]  descramblerDataK,
    output logic        osValid,
    output logic        osType,
    output logic [7:0]  linkNum,
    output logic [7:0]  laneNum,
    output logic [7:0]  nFts,
    output logic [7:0]  rateId,
    output logic [7:0]  trainCtrl,
    output logic [7:0]  tsCount,
    output logic        osError,
    output logic [15:0] errCount
);

    typedef enum logic [1:0] {IDLE, W1, W2, W3} state_e;

    localparam logic [7:0] COM      = 8'hBC;
    localparam logic [7:0] ID_TS1   = 8'h4A;
    localparam logic [7:0] ID_TS2   = 8'h45;
    localparam logic [7:0] G3_TS1   = 8'h1E;
    localparam logic [7:0] G3_TS2   = 8'h2D;

    state_e     state_q, state_d;
    logic       mode_q, mode_d;
    logic       cur_type_q, cur_type_d;
    logic [7:0] cur_link_q, cur_link_d;
    logic [7:0] cur_lane_q, cur_lane_d;
    logic [7:0] cur_nfts_q, cur_nfts_d;
    logic [7:0] cur_rate_q, cur_rate_d;
    logic [7:0] cur_ctrl_q, cur_ctrl_d;

    logic       os_valid_q, os_valid_d;
    logic       os_error_q, os_error_d;
    logic       os_type_q, os_type_d;
    logic [7:0] link_q, link_d;
    logic [7:0] lane_q, lane_d;
    logic [7:0] nfts_q, nfts_d;
    logic [7:0] rate_q, rate_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] ts_count_q, ts_count_d;
    logic       hist_valid_q, hist_valid_d;

    logic [7:0] sym0, sym1, sym2, sym3;
    logic [7:0] exp_id;
    logic       framing_ok, w1_id_ok, all_id, hi_id, lo_id, same_os;
    logic       good, bad;

    assign sym0 = descramblerData[7:0];
    assign sym1 = descramblerData[15:8];
    assign sym2 = descramblerData[23:16];
    assign sym3 = descramblerData[31:24];

    assign exp_id = cur_type_q ? ID_TS2 : ID_TS1;
    // A mode change since the OS start fails framing regardless of the word contents.
    assign framing_ok = (gen3Mode == mode_q) &&
                        (mode_q ? (descramblerSyncHeader == 2'b01) : (descramblerDataK == 4'b0000));
    assign w1_id_ok = ((sym2 == ID_TS1) || (sym2 == ID_TS2)) && (sym3 == sym2);
    assign lo_id    = (sym0 == exp_id) && (sym1 == exp_id);
    assign hi_id    = (sym2 == exp_id) && (sym3 == exp_id);
    assign all_id   = lo_id && hi_id;
    assign same_os  = hist_valid_q && (cur_type_q == os_type_q) && (cur_link_q == link_q) &&
                      (cur_lane_q == lane_q) && (cur_rate_q == rate_q) && (cur_ctrl_q == ctrl_q);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cur_type_d   = cur_type_q;
        cur_link_d   = cur_link_q;
        cur_lane_d   = cur_lane_q;
        cur_nfts_d   = cur_nfts_q;
        cur_rate_d   = cur_rate_q;
        cur_ctrl_d   = cur_ctrl_q;
        os_valid_d   = 1'b0;
        os_error_d   = 1'b0;
        os_type_d    = os_type_q;
        link_d       = link_q;
        lane_d       = lane_q;
        nfts_d       = nfts_q;
        rate_d       = rate_q;
        ctrl_d       = ctrl_q;
        ts_count_d   = ts_count_q;
        hist_valid_d = hist_valid_q;
        good         = 1'b0;
        bad          = 1'b0;

        if (descramblerDataValid) begin
            case (state_q)
                IDLE: begin
                    if (!gen3Mode && descramblerDataK[0] && (sym0 == COM)) begin
                        mode_d     = 1'b0;
                        cur_link_d = sym1;
                        cur_lane_d = sym2;
                        cur_nfts_d = sym3;
                        if (descramblerDataK[3:1] != 3'b000) bad = 1'b1;
                        else state_d = W1;
                    end else if (gen3Mode && (descramblerSyncHeader == 2'b01) &&
                                 ((sym0 == G3_TS1) || (sym0 == G3_TS2))) begin
                        mode_d     = 1'b1;
                        cur_type_d = (sym0 == G3_TS2);
                        cur_link_d = sym1;
                        cur_lane_d = sym2;
                        cur_nfts_d = sym3;
                        state_d    = W1;
                    end
                end
                W1: begin
                    if (!framing_ok || (!mode_q && !w1_id_ok)) bad = 1'b1;
                    else begin
                        if (!mode_q) cur_type_d = (sym2 == ID_TS2);
                        cur_rate_d = sym0;
                        cur_ctrl_d = sym1;
                        state_d    = W2;
                    end
                end
                W2: begin
                    if (!framing_ok || !(mode_q ? hi_id : all_id)) bad = 1'b1;
                    else state_d = W3;
                end
                W3: begin
                    if (!framing_ok || !(mode_q ? lo_id : all_id)) bad = 1'b1;
                    else good = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end

        if (bad) begin
            state_d      = IDLE;
            os_error_d   = 1'b1;
            ts_count_d   = '0;
            hist_valid_d = 1'b0;
        end
        if (good) begin
            state_d      = IDLE;
            os_valid_d   = 1'b1;
            os_type_d    = cur_type_q;
            link_d       = cur_link_q;
            lane_d       = cur_lane_q;
            nfts_d       = cur_nfts_q;
            rate_d       = cur_rate_q;
            ctrl_d       = cur_ctrl_q;
            hist_valid_d = 1'b1;
            if (!same_os)                ts_count_d = 8'd1;
            else if (ts_count_q != 8'hFF) ts_count_d = ts_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            cur_type_q   <= 1'b0;
            cur_link_q   <= '0;
            cur_lane_q   <= '0;
            cur_nfts_q   <= '0;
            cur_rate_q   <= '0;
            cur_ctrl_q   <= '0;
            os_valid_q   <= 1'b0;
            os_error_q   <= 1'b0;
            os_type_q    <= 1'b0;
            link_q       <= '0;
            lane_q       <= '0;
            nfts_q       <= '0;
            rate_q       <= '0;
            ctrl_q       <= '0;
            ts_count_q   <= '0;
            hist_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cur_type_q   <= cur_type_d;
            cur_link_q   <= cur_link_d;
            cur_lane_q   <= cur_lane_d;
            cur_nfts_q   <= cur_nfts_d;
            cur_rate_q   <= cur_rate_d;
            cur_ctrl_q   <= cur_ctrl_d;
            os_valid_q   <= os_valid_d;
            os_error_q   <= os_error_d;
            os_type_q    <= os_type_d;
            link_q       <= link_d;
            lane_q       <= lane_d;
            nfts_q       <= nfts_d;
            rate_q       <= rate_d;
            ctrl_q       <= ctrl_d;
            ts_count_q   <= ts_count_d;
            hist_valid_q <= hist_valid_d;
        end
    end

`ifdef TS_OS_ERR_CNT_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        err_count_d = err_count_q;
        if (os_error_d && (err_count_q != 16'hFFFF)) err_count_d = err_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err_count_q <= '0;
        else        err_count_q <= err_count_d;
    end

    assign errCount = err_count_q;
`else
    assign errCount = '0;
`endif

    assign osValid   = os_valid_q;
    assign osError   = os_error_q;
    assign osType    = os_type_q;
    assign linkNum   = link_q;
    assign laneNum   = lane_q;
    assign nFts      = nfts_q;
    assign rateId    = rate_q;
    assign trainCtrl = ctrl_q;
    assign tsCount   = ts_count_q;

endmodule

// File: tb/tb_ts_os_detector.sv
// Directed table-driven bench for ts_os_detector; each row is one input word plus the
// outputs expected one edge later.
module tb_ts_os_detector;

    logic        clk = 1'b0;
    logic        reset;
    logic        gen3Mode;
    logic        v;
    logic [1:0]  sh;
    logic [31:0] data;
    logic [3:0]  k;
    logic        osValid, osType, osError;
    logic [7:0]  linkNum, laneNum, nFts, rateId, trainCtrl, tsCount;
    logic [15:0] errCount;

    always #5 clk = ~clk;

    ts_os_detector u_dut (
        .clk(clk), .reset(reset), .gen3Mode(gen3Mode),
        .descramblerDataValid(v), .descramblerSyncHeader(sh),
        .descramblerData(data), .descramblerDataK(k),
        .osValid(osValid), .osType(osType), .linkNum(linkNum), .laneNum(laneNum),
        .nFts(nFts), .rateId(rateId), .trainCtrl(trainCtrl), .tsCount(tsCount),
        .osError(osError), .errCount(errCount)
    );

    typedef struct {
        logic        v;
        logic        g3;
        logic [1:0]  sh;
        logic [31:0] d;
        logic [3:0]  k;
        logic        e_valid;
        logic        e_err;
        logic        e_type;
        logic [7:0]  e_link, e_lane, e_nfts, e_rate, e_ctrl, e_cnt;
        logic [15:0] e_errc;
    } vec_t;

    vec_t vq[$];
    int   tests = 0;
    int   fails = 0;

    logic        x_type;
    logic [7:0]  x_link, x_lane, x_nfts, x_rate, x_ctrl, x_cnt;
    logic [15:0] x_errc;

    task automatic clear_exp();
        x_type = 1'b0; x_link = '0; x_lane = '0; x_nfts = '0;
        x_rate = '0;   x_ctrl = '0; x_cnt  = '0; x_errc = '0;
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic push(input logic vv, input logic g3, input logic [1:0] s, input logic [31:0] d,
                        input logic [3:0] kk, input logic ev, input logic ee);
        vec_t r;
        r.v = vv; r.g3 = g3; r.sh = s; r.d = d; r.k = kk;
        r.e_valid = ev; r.e_err = ee; r.e_type = x_type;
        r.e_link = x_link; r.e_lane = x_lane; r.e_nfts = x_nfts;
        r.e_rate = x_rate; r.e_ctrl = x_ctrl; r.e_cnt = x_cnt; r.e_errc = x_errc;
        vq.push_back(r);
    endtask

    task automatic push_stall(input logic g3);
        push(1'b0, g3, 2'($urandom), $urandom, 4'($urandom), 1'b0, 1'b0);
    endtask

    // bad=1 corrupts the third word: symbol 11 -> 0x4B (8b/10b) or sync header 2'b10 (128b/130b).
    task automatic add_os(input logic g3, input logic typ, input logic [7:0] link, input logic [7:0] lane,
                          input logic [7:0] nfts, input logic [7:0] rate, input logic [7:0] ctrl,
                          input logic [7:0] cnt, input logic stall, input logic bad);
        logic [7:0]  id;
        logic [31:0] w0, w1, w2, w3;
        logic [3:0]  k0;
        id = typ ? 8'h45 : 8'h4A;
        if (!g3) begin
            w0 = {nfts, lane, link, 8'hBC}; k0 = 4'b0001;
            w1 = {id, id, ctrl, rate};
            w2 = {id, id, id, id};
            w3 = {id, id, id, id};
            if (bad) w2[31:24] = 8'h4B;
        end else begin
            w0 = {nfts, lane, link, (typ ? 8'h2D : 8'h1E)}; k0 = 4'b0000;
            w1 = {8'h5A, 8'hA5, ctrl, rate};
            w2 = {id, id, 8'h11, 8'h22};
            w3 = {8'h33, 8'h44, id, id};
        end
        push(1'b1, g3, 2'b01, w0, k0, 1'b0, 1'b0);
        if (stall) push_stall(g3);
        push(1'b1, g3, 2'b01, w1, 4'b0000, 1'b0, 1'b0);
        if (stall) push_stall(g3);
        if (bad) begin
            x_cnt = 8'd0;
`ifdef TS_OS_ERR_CNT_EN
            x_errc = x_errc + 16'd1;
`endif
            push(1'b1, g3, (g3 ? 2'b10 : 2'b01), w2, 4'b0000, 1'b0, 1'b1);
            return;
        end
        push(1'b1, g3, 2'b01, w2, 4'b0000, 1'b0, 1'b0);
        if (stall) push_stall(g3);
        x_type = typ; x_link = link; x_lane = lane; x_nfts = nfts;
        x_rate = rate; x_ctrl = ctrl; x_cnt = cnt;
        push(1'b1, g3, 2'b01, w3, 4'b0000, 1'b1, 1'b0);
    endtask

    task automatic apply(input vec_t r, input int idx);
        @(negedge clk);
        v = r.v; gen3Mode = r.g3; sh = r.sh; data = r.d; k = r.k;
        @(posedge clk);
        #1;
        chk("osValid",   idx, 32'(osValid),   32'(r.e_valid));
        chk("osError",   idx, 32'(osError),   32'(r.e_err));
        chk("osType",    idx, 32'(osType),    32'(r.e_type));
        chk("tsCount",   idx, 32'(tsCount),   32'(r.e_cnt));
        chk("linkNum",   idx, 32'(linkNum),   32'(r.e_link));
        chk("laneNum",   idx, 32'(laneNum),   32'(r.e_lane));
        chk("nFts",      idx, 32'(nFts),      32'(r.e_nfts));
        chk("rateId",    idx, 32'(rateId),    32'(r.e_rate));
        chk("trainCtrl", idx, 32'(trainCtrl), 32'(r.e_ctrl));
        chk("errCount",  idx, 32'(errCount),  32'(r.e_errc));
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_osValid"},  0, 32'(osValid),  32'd0);
        chk({nm, "_osError"},  0, 32'(osError),  32'd0);
        chk({nm, "_osType"},   0, 32'(osType),   32'd0);
        chk({nm, "_fields"},   0, {linkNum, laneNum, nFts, rateId}, 32'd0);
        chk({nm, "_ctrl"},     0, 32'(trainCtrl), 32'd0);
        chk({nm, "_tsCount"},  0, 32'(tsCount),  32'd0);
        chk({nm, "_errCount"}, 0, 32'(errCount), 32'd0);
    endtask

    initial begin
        reset = 1'b0; gen3Mode = 1'b0; v = 1'b0; sh = 2'b00; data = '0; k = '0;
        clear_exp();
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Vector table.
        push(1'b1, 1'b0, 2'b00, 32'h1234_5678, 4'b0000, 1'b0, 1'b0);
        push(1'b1, 1'b0, 2'b00, 32'h0000_00BC, 4'b0000, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            add_os(1'b0, 1'b0, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00, 8'(i + 1), 1'b0, 1'b0);
        add_os(1'b0, 1'b0, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00, 8'd0, 1'b0, 1'b1);
        add_os(1'b0, 1'b0, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00, 8'd1, 1'b0, 1'b0);
        add_os(1'b0, 1'b0, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00, 8'd2, 1'b0, 1'b0);
        add_os(1'b0, 1'b1, 8'h00, 8'h03, 8'h10, 8'h02, 8'h00, 8'd1, 1'b0, 1'b0);
        add_os(1'b0, 1'b1, 8'h00, 8'h04, 8'h10, 8'h02, 8'h00, 8'd1, 1'b0, 1'b0);
        add_os(1'b0, 1'b1, 8'h00, 8'h04, 8'h10, 8'h02, 8'h00, 8'd2, 1'b0, 1'b0);
        add_os(1'b1, 1'b1, 8'h05, 8'h01, 8'h20, 8'h04, 8'h08, 8'd1, 1'b1, 1'b0);
        add_os(1'b1, 1'b0, 8'h05, 8'h01, 8'h20, 8'h04, 8'h08, 8'd1, 1'b0, 1'b0);
        add_os(1'b1, 1'b0, 8'h05, 8'h01, 8'h20, 8'h04, 8'h08, 8'd2, 1'b0, 1'b0);
        add_os(1'b1, 1'b0, 8'h05, 8'h01, 8'h20, 8'h04, 8'h08, 8'd0, 1'b0, 1'b1);
        for (int i = 0; i < 260; i++)
            add_os(1'b0, 1'b1, 8'h07, 8'h00, 8'h1F, 8'h02, 8'h40,
                   ((i + 1) > 255) ? 8'd255 : 8'(i + 1), 1'b0, 1'b0);

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // Reset while the FSM is waiting for the third word.
        vq.delete();
        add_os(1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'd1, 1'b0, 1'b0);
        apply(vq[0], 9000);
        apply(vq[1], 9001);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_zero("midreset");
        clear_exp();
        @(negedge clk);
        reset = 1'b1; v = 1'b0;
        @(posedge clk);
        #1;
        chk("release_osValid", 0, 32'(osValid), 32'd0);
        chk("release_osError", 0, 32'(osError), 32'd0);
        vq.delete();
        add_os(1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'd1, 1'b0, 1'b0);
        add_os(1'b0, 1'b0, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'd2, 1'b0, 1'b0);
        for (int i = 0; i < vq.size(); i++) apply(vq[i], 9100 + i);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
